wb_spi_flash_reader: RTL and testbench
======================================

// Module: wb_spi_flash_reader
// PURPOSE
// Wishbone master sitting directly upstream of wb_to_spi_master. Turns one AXI-Stream read
// command (24-bit flash address, length) into a 0x03 READ sequence on the SPI master:
// - assert SS, send opcode and address, clock out dummy bytes
// - stream the returned flash bytes on an AXI-Stream output, then release SS.
// PARAMETERS
// ADDR_BITS    8      Wishbone address width; matches wb_to_spi_master
// CFG_ADDR     8'h01  SPI master config register; bit0 = SS level
// DATA_ADDR    8'h02  SPI master data port; write = send byte, read = pop received byte
// READ_OPCODE  8'h03  flash read opcode
// LEN_BITS     16     width of the length field
// PORTS
// clk            in   1          single clock
// sresetn        in   1          asynchronous, active-low reset
// cmd_tvalid     in   1          command valid
// cmd_tready     out  1          command accepted when tvalid&&tready
// cmd_addr       in   24         flash byte address, sent MSB first
// cmd_len        in   LEN_BITS   bytes to read minus 1 (0 = 1 byte)
// m_axis_tvalid  out  1          read data valid
// m_axis_tready  in   1          downstream ready
// m_axis_tdata   out  8          read data byte
// m_axis_tlast   out  1          high on final byte of the command
// m_wb_addr      out  ADDR_BITS  Wishbone address
// m_wb_dat_m2s   out  8          Wishbone write data
// m_wb_dat_s2m   in   8          Wishbone read data
// m_wb_we        out  1          Wishbone write enable
// m_wb_sel       out  1          Wishbone byte select; tied 1
// m_wb_stb       out  1          Wishbone strobe
// m_wb_cyc       out  1          Wishbone cycle
// m_wb_ack       in   1          Wishbone acknowledge
// m_wb_stall     in   1          Wishbone stall
// busy           out  1          high whenever state != IDLE
// BEHAVIOUR
// Reset (async assert, sync release):
// - state=IDLE; stb, cyc, we, m_axis_tvalid, m_axis_tlast, busy = 0; cmd_tready=1
// - addr and dat_m2s = 0
// - An in-flight Wishbone cycle or partial AXIS byte is dropped; no SS-release cleanup.
//   The system resets this block and wb_to_spi_master together.
// Wishbone access (pipelined, at most one outstanding):
// - Issue: cyc=stb=1 until a cycle with !stall; then stb=0, cyc=1 until ack; cyc=0 the cycle after ack.
// - Read data is captured on the ack cycle.
// - addr, we and dat_m2s stay constant from issue until ack.
// - An ack arriving in the same cycle as the accepted strobe is legal; the access completes.
// Command:
// - cmd_tready=1 only in IDLE.
// - On handshake, latch cmd_addr and cmd_len; set byte counter = 0 and header index = 0.
// State machine, one Wishbone access per state:
// - SS_LO: write 0x00 to CFG_ADDR.
// - HDR_TX: write header byte to DATA_ADDR, in order opcode, addr[23:16], addr[15:8], addr[7:0].
// - HDR_RX: read DATA_ADDR and discard.
//   - From HDR_RX: back to HDR_TX for the next header byte; after the 4th byte go to DAT_TX.
// - DAT_TX: write 0x00 to DATA_ADDR.
// - DAT_RX: read DATA_ADDR into the output register; go to OUT.
// - OUT: m_axis_tvalid=1 and tlast=(counter==len); hold until tready.
//   - On handshake: if last go to SS_HI, else counter+1 and go to DAT_TX.
// - SS_HI: write 0x01 to CFG_ADDR; then IDLE with cmd_tready=1 the next cycle.
// AXIS backpressure:
// - No new SPI byte is started while a byte sits unaccepted in OUT; no data is lost.
// - tdata and tlast are stable while tvalid && !tready.
// Counter and length:
// - Counter is LEN_BITS wide.
// - cmd_len = 2^LEN_BITS-1 reads 2^LEN_BITS bytes and the counter never wraps.
// Flash address:
// - Only the start address is sent; the flash auto-increments.
// - Address wrap inside the flash is the flash's behaviour and is not checked here.
// Stall and ack timing:
// - stall held indefinitely keeps stb asserted; ack arriving late keeps cyc asserted. No timeout.
// TESTING
// 1. Read cmd addr=0x123456 len=0 with a zero-wait slave:
//    - WB writes in order: CFG=00, DATA 03, 12, 34, 56, 00, then CFG=01.
//    - One AXIS beat with tlast=1 carrying the slave's 5th read byte (e.g. 0xA5).
//    - cmd_tready=1 after the sequence.
// 2. len=3, model returns 0x10..0x13 on data reads:
//    - Beats 0x10, 0x11, 0x12, 0x13; tlast only on 0x13.
//    - Exactly 8 DATA reads in total.
// 3. m_axis_tready low for 20 cycles on the 2nd beat:
//    - tvalid and tdata held; no Wishbone strobe during the hold; stream intact after release.
// 4. Random stall (50%) and ack delay 0-5 cycles:
//    - Identical access sequence and data to test 2.
//    - Never two outstanding strobes; addr and we stable until ack.
// 5. sresetn pulsed low mid-DAT_TX:
//    - stb, cyc and tvalid drop immediately (async); IDLE after release.
//    - A new command completes correctly.
// 6. cmd_tvalid asserted while busy:
//    - cmd_tready stays 0; the command is accepted the cycle after SS_HI completes.

Source files
------------

// File: rtl/wb_spi_flash_reader_if.sv
// Bus bundle for wb_spi_flash_reader: read-command stream in, read-data stream out,
// and the Wishbone master port that drives wb_to_spi_master.
interface wb_spi_flash_reader_if #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LEN_BITS  = 16
);
  // Streams transfer on each rising edge with valid && ready; the source holds its
  // payload stable and keeps valid high until accepted. A Wishbone strobe is accepted
  // on an edge with stb && !stall, and the access ends on the edge with ack.
  logic                 cmd_tvalid;
  logic                 cmd_tready;
  logic [23:0]          cmd_addr;
  logic [LEN_BITS-1:0]  cmd_len;

  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [7:0]           m_axis_tdata;
  logic                 m_axis_tlast;

  logic [ADDR_BITS-1:0] m_wb_addr;
  logic [7:0]           m_wb_dat_m2s;
  logic [7:0]           m_wb_dat_s2m;
  logic                 m_wb_we;
  logic                 m_wb_sel;
  logic                 m_wb_stb;
  logic                 m_wb_cyc;
  logic                 m_wb_ack;
  logic                 m_wb_stall;

  modport master (
    input  cmd_tvalid, cmd_addr, cmd_len,
    output cmd_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tlast,
    input  m_axis_tready,
    output m_wb_addr, m_wb_dat_m2s, m_wb_we, m_wb_sel, m_wb_stb, m_wb_cyc,
    input  m_wb_dat_s2m, m_wb_ack, m_wb_stall
  );

  modport slave (
    output cmd_tvalid, cmd_addr, cmd_len,
    input  cmd_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tlast,
    output m_axis_tready,
    input  m_wb_addr, m_wb_dat_m2s, m_wb_we, m_wb_sel, m_wb_stb, m_wb_cyc,
    output m_wb_dat_s2m, m_wb_ack, m_wb_stall
  );
endinterface

// File: rtl/wb_spi_flash_reader.sv
// Turns one read command into a flash 0x03 READ through wb_to_spi_master's register
// interface and streams the returned bytes out; one Wishbone access per FSM state.
module wb_spi_flash_reader #(
  parameter int unsigned          ADDR_BITS   = 8,
  parameter logic [ADDR_BITS-1:0] CFG_ADDR    = 'h01,
  parameter logic [ADDR_BITS-1:0] DATA_ADDR   = 'h02,
  parameter logic [7:0]           READ_OPCODE = 8'h03,
  parameter int unsigned          LEN_BITS    = 16
) (
  input  logic                        clk,
  input  logic                        sresetn,
  wb_spi_flash_reader_if.master       bus,
  output logic                        busy,
  output logic [2:0]                  dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SS_LO  = 3'd1,
    HDR_TX = 3'd2,
    HDR_RX = 3'd3,
    DAT_TX = 3'd4,
    DAT_RX = 3'd5,
    OUT    = 3'd6,
    SS_HI  = 3'd7
  } state_e;

  state_e               state_q, state_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]           dat_q, dat_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic [7:0]           tdata_q, tdata_d;
  logic                 cmd_tready_q, cmd_tready_d;
  logic [23:0]          fl_addr_q, fl_addr_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [LEN_BITS-1:0]  cnt_q, cnt_d;
  logic [1:0]           hdr_q, hdr_d;

  logic                 acc_done;
  logic                 need_acc;
  logic                 acc_we;
  logic [ADDR_BITS-1:0] acc_addr;
  logic [7:0]           acc_dat;
  logic [7:0]           hdr_byte;

  always_comb begin
    case (hdr_q)
      2'd0:    hdr_byte = READ_OPCODE;
      2'd1:    hdr_byte = fl_addr_q[23:16];
      2'd2:    hdr_byte = fl_addr_q[15:8];
      default: hdr_byte = fl_addr_q[7:0];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    addr_d       = addr_q;
    dat_d        = dat_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tdata_d      = tdata_q;
    cmd_tready_d = cmd_tready_q;
    fl_addr_d    = fl_addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    hdr_d        = hdr_q;
    need_acc     = 1'b0;
    acc_we       = 1'b1;
    acc_addr     = DATA_ADDR;
    acc_dat      = 8'h00;
    acc_done     = cyc_q && bus.m_wb_ack;

    // Strobe drops once accepted; an ack in that same cycle also ends the access.
    if (stb_q && !bus.m_wb_stall) stb_d = 1'b0;
    if (acc_done) begin
      cyc_d = 1'b0;
      stb_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.cmd_tvalid && cmd_tready_q) begin
          fl_addr_d    = bus.cmd_addr;
          len_d        = bus.cmd_len;
          cnt_d        = '0;
          hdr_d        = 2'd0;
          cmd_tready_d = 1'b0;
          state_d      = SS_LO;
        end
      end
      SS_LO: begin
        need_acc = 1'b1;
        acc_addr = CFG_ADDR;
        if (acc_done) state_d = HDR_TX;
      end
      HDR_TX: begin
        need_acc = 1'b1;
        acc_dat  = hdr_byte;
        if (acc_done) state_d = HDR_RX;
      end
      HDR_RX: begin
        need_acc = 1'b1;
        acc_we   = 1'b0;
        if (acc_done) begin
          if (hdr_q == 2'd3) begin
            state_d = DAT_TX;
          end else begin
            hdr_d   = hdr_q + 2'd1;
            state_d = HDR_TX;
          end
        end
      end
      DAT_TX: begin
        need_acc = 1'b1;
        if (acc_done) state_d = DAT_RX;
      end
      DAT_RX: begin
        need_acc = 1'b1;
        acc_we   = 1'b0;
        if (acc_done) begin
          tdata_d  = bus.m_wb_dat_s2m;
          tvalid_d = 1'b1;
          tlast_d  = (cnt_q == len_q);
          state_d  = OUT;
        end
      end
      OUT: begin
        // No Wishbone traffic here, so a stalled consumer simply pauses the SPI clock.
        if (bus.m_axis_tready) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          if (tlast_q) begin
            state_d = SS_HI;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = DAT_TX;
          end
        end
      end
      SS_HI: begin
        need_acc = 1'b1;
        acc_addr = CFG_ADDR;
        acc_dat  = 8'h01;
        if (acc_done) begin
          cmd_tready_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A state's access is issued when the bus is idle, leaving one cyc-low cycle after each ack.
    if (need_acc && !cyc_q) begin
      cyc_d  = 1'b1;
      stb_d  = 1'b1;
      we_d   = acc_we;
      addr_d = acc_addr;
      dat_d  = acc_dat;
    end
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q      <= IDLE;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      dat_q        <= 8'h00;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= 8'h00;
      cmd_tready_q <= 1'b1;
      fl_addr_q    <= 24'h000000;
      len_q        <= '0;
      cnt_q        <= '0;
      hdr_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      dat_q        <= dat_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
      cmd_tready_q <= cmd_tready_d;
      fl_addr_q    <= fl_addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      hdr_q        <= hdr_d;
    end
  end

  assign bus.cmd_tready    = cmd_tready_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.m_wb_addr     = addr_q;
  assign bus.m_wb_dat_m2s  = dat_q;
  assign bus.m_wb_we       = we_q;
  assign bus.m_wb_sel      = 1'b1;
  assign bus.m_wb_stb      = stb_q;
  assign bus.m_wb_cyc      = cyc_q;
  assign busy              = (state_q != IDLE);
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_wb_spi_flash_reader.sv
// Directed + randomized bench for wb_spi_flash_reader: Wishbone slave model with random
// stall/ack delay, AXIS sink with backpressure, and a transaction-level expected model.
module tb_wb_spi_flash_reader;
  localparam int ADDR_BITS = 8;
  localparam int LEN_BITS  = 3;
  localparam logic [7:0] CFG = 8'h01;
  localparam logic [7:0] DAT = 8'h02;

  logic       clk = 1'b0;
  logic       sresetn = 1'b1;
  logic       busy;
  logic [2:0] dbg_state;

  wb_spi_flash_reader_if #(.ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS)) bus ();

  wb_spi_flash_reader #(.ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS)) dut (
    .clk(clk), .sresetn(sresetn), .bus(bus), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- shared configuration and scoreboard state
  int checks = 0;
  int errors = 0;
  int stall_pct = 0, dly_min = 0, dly_max = 0, ready_pct = 100;
  int hold_idx = -1, hold_len = 0;
  int mon_viol = 0, hold_viol = 0, hold_total = 0;
  int rd_cnt = 0, rd_total = 0, sshi_ack_cyc = 0, cyc_cnt = 0;
  int log_base = 0, beat_base = 0;
  logic [7:0]  rd_vals [0:1023];
  logic [16:0] acc_log[$];   // {addr, we, write data or 0}
  logic [16:0] exp_acc[$];
  logic [8:0]  got_beats[$]; // {tlast, tdata}
  logic [8:0]  exp_beats[$];

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  function automatic logic [16:0] wb_now();
    return {bus.m_wb_addr, bus.m_wb_we, (bus.m_wb_we ? bus.m_wb_dat_m2s : 8'h00)};
  endfunction

  task automatic slave_ack(input logic [16:0] a);
    bus.m_wb_ack = 1'b1;
    if (!a[8]) begin
      bus.m_wb_dat_s2m = rd_vals[rd_cnt];
      rd_cnt++;
    end
    if (a == {CFG, 1'b1, 8'h01}) sshi_ack_cyc = cyc_cnt;
  endtask

  // ---------------- Wishbone slave: decisions at negedge take effect at the next posedge
  initial begin : wb_slave
    bit pend, ack_prev;
    int dly;
    logic [16:0] cur;
    pend = 0; ack_prev = 0; dly = 0; cur = '0;
    bus.m_wb_ack = 1'b0; bus.m_wb_stall = 1'b0; bus.m_wb_dat_s2m = 8'h00;
    forever begin
      @(negedge clk);
      bus.m_wb_ack   = 1'b0;
      bus.m_wb_stall = 1'b0;
      if (sresetn !== 1'b1) begin
        pend = 0; ack_prev = 0;
      end else if (ack_prev) begin
        ack_prev = 0;
        if (bus.m_wb_cyc !== 1'b0 || bus.m_wb_stb !== 1'b0) mon_viol++;
      end else if (pend) begin
        if (bus.m_wb_stb !== 1'b0 || bus.m_wb_cyc !== 1'b1 || wb_now() !== cur) mon_viol++;
        dly--;
        if (dly <= 0) begin
          slave_ack(cur);
          pend = 0; ack_prev = 1;
        end
      end else if (bus.m_wb_stb === 1'b1) begin
        if (bus.m_wb_cyc !== 1'b1) mon_viol++;
        if ($urandom_range(99) < stall_pct) begin
          bus.m_wb_stall = 1'b1;
        end else begin
          cur = wb_now();
          acc_log.push_back(cur);
          dly = $urandom_range(dly_max, dly_min);
          if (dly == 0) begin
            slave_ack(cur);
            ack_prev = 1;
          end else begin
            pend = 1;
          end
        end
      end else if (bus.m_wb_cyc === 1'b1) begin
        mon_viol++;
      end
    end
  end

  // ---------------- AXIS sink with optional hold on one beat index
  initial begin : axis_sink
    int held;
    logic [8:0] hv;
    held = 0; hv = '0;
    bus.m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      if (got_beats.size() != hold_idx) held = 0;
      if (sresetn !== 1'b1) begin
        bus.m_axis_tready = 1'b0;
        held = 0;
      end else if (got_beats.size() == hold_idx && held < hold_len &&
                   (held > 0 || bus.m_axis_tvalid === 1'b1)) begin
        if (bus.m_axis_tvalid !== 1'b1 || bus.m_wb_stb !== 1'b0 ||
            (held > 0 && {bus.m_axis_tlast, bus.m_axis_tdata} !== hv)) hold_viol++;
        hv = {bus.m_axis_tlast, bus.m_axis_tdata};
        held++;
        hold_total++;
        bus.m_axis_tready = 1'b0;
      end else begin
        bus.m_axis_tready = ($urandom_range(99) < ready_pct);
        if (bus.m_axis_tready && bus.m_axis_tvalid === 1'b1)
          got_beats.push_back({bus.m_axis_tlast, bus.m_axis_tdata});
      end
    end
  end

  // ---------------- checking helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the access list and beats a READ of len+1 bytes must produce.
  task automatic model_cmd(input logic [23:0] a, input int len, input bit incr, input logic [7:0] base);
    logic [7:0] hdr [4];
    logic [7:0] v;
    hdr[0] = 8'h03; hdr[1] = a[23:16]; hdr[2] = a[15:8]; hdr[3] = a[7:0];
    exp_acc.push_back({CFG, 1'b1, 8'h00});
    for (int i = 0; i < 4; i++) begin
      exp_acc.push_back({DAT, 1'b1, hdr[i]});
      exp_acc.push_back({DAT, 1'b0, 8'h00});
      rd_vals[rd_total] = 8'($urandom);
      rd_total++;
    end
    for (int i = 0; i <= len; i++) begin
      exp_acc.push_back({DAT, 1'b1, 8'h00});
      exp_acc.push_back({DAT, 1'b0, 8'h00});
      v = incr ? 8'(base + i) : 8'($urandom);
      rd_vals[rd_total] = v;
      rd_total++;
      exp_beats.push_back({(i == len), v});
    end
    exp_acc.push_back({CFG, 1'b1, 8'h01});
  endtask

  task automatic send_cmd(input string tag, input logic [23:0] a, input int len);
    int n;
    n = 0;
    bus.cmd_addr = a;
    bus.cmd_len = LEN_BITS'(len);
    bus.cmd_tvalid = 1'b1;
    while (bus.cmd_tready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " cmd accepted"}, (n < 5000), 1);
    @(posedge clk);
    #1 bus.cmd_tvalid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((acc_log.size() - log_base) >= exp_acc.size() &&
                 (got_beats.size() - beat_base) >= exp_beats.size() && busy === 1'b0) && n < 5000);
    if (n >= 5000) $display("timeout in %s, dbg_state=%0d", tag, dbg_state);
    check({tag, " completion"}, (n < 5000), 1);
    check({tag, " cmd_tready idle"}, bus.cmd_tready, 1);
  endtask

  task automatic compare(input string tag);
    int na, nb;
    na = acc_log.size() - log_base;
    nb = got_beats.size() - beat_base;
    check({tag, " access count"}, na, exp_acc.size());
    for (int i = 0; i < exp_acc.size() && i < na; i++)
      check({tag, " access"}, acc_log[log_base + i], exp_acc[i]);
    check({tag, " beat count"}, nb, exp_beats.size());
    for (int i = 0; i < exp_beats.size() && i < nb; i++)
      check({tag, " beat"}, got_beats[beat_base + i], exp_beats[i]);
    check({tag, " wb protocol violations"}, mon_viol, 0);
    log_base += na;
    beat_base += nb;
    exp_acc.delete();
    exp_beats.delete();
  endtask

  // ---------------- directed sequence
  initial begin : main
    int n, h0;
    bus.cmd_tvalid = 1'b0;
    bus.cmd_addr = 24'h0;
    bus.cmd_len = '0;
    #2 sresetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst stb", bus.m_wb_stb, 0);
    check("rst cyc", bus.m_wb_cyc, 0);
    check("rst we", bus.m_wb_we, 0);
    check("rst addr", bus.m_wb_addr, 0);
    check("rst dat", bus.m_wb_dat_m2s, 0);
    check("rst sel", bus.m_wb_sel, 1);
    check("rst tvalid", bus.m_axis_tvalid, 0);
    check("rst tlast", bus.m_axis_tlast, 0);
    check("rst busy", busy, 0);
    check("rst cmd_tready", bus.cmd_tready, 1);
    sresetn = 1'b1;
    @(negedge clk);

    // 1: single byte, zero-wait slave
    model_cmd(24'h123456, 0, 1'b1, 8'hA5);
    send_cmd("t1", 24'h123456, 0);
    wait_done("t1");
    compare("t1");

    // 2: four bytes, incrementing data
    model_cmd(24'hABCDEF, 3, 1'b1, 8'h10);
    send_cmd("t2", 24'hABCDEF, 3);
    wait_done("t2");
    n = 0;
    for (int i = log_base; i < acc_log.size(); i++)
      if (acc_log[i][16:9] == DAT && acc_log[i][8] == 1'b0) n++;
    check("t2 data reads", n, 8);
    compare("t2");

    // 3: hold the second beat for 20 cycles
    h0 = hold_total;
    hold_idx = beat_base + 1;
    hold_len = 20;
    model_cmd(24'h000100, 3, 1'b1, 8'h10);
    send_cmd("t3", 24'h000100, 3);
    wait_done("t3");
    check("t3 hold cycles", hold_total - h0, 20);
    check("t3 hold violations", hold_viol, 0);
    compare("t3");
    hold_idx = -1;

    // 4: random stall and ack delay, same transfer as 2
    stall_pct = 50; dly_min = 0; dly_max = 5;
    model_cmd(24'hABCDEF, 3, 1'b1, 8'h10);
    send_cmd("t4", 24'hABCDEF, 3);
    wait_done("t4");
    compare("t4");

    // 4b: random commands incl. max length, random backpressure
    ready_pct = 70;
    for (int k = 0; k < 6; k++) begin
      logic [23:0] a;
      int len;
      a = 24'($urandom);
      len = (k == 0) ? 7 : int'($urandom_range(7, 0));
      model_cmd(a, len, 1'b0, 8'h00);
      send_cmd("rnd", a, len);
      wait_done("rnd");
      compare("rnd");
    end
    ready_pct = 100;

    // 5: reset in the middle of the first DAT_TX access
    stall_pct = 0; dly_min = 4; dly_max = 4;
    model_cmd(24'h555555, 5, 1'b1, 8'h40);
    while (exp_acc.size() > 10) void'(exp_acc.pop_back());
    exp_beats.delete();
    rd_total -= 6;
    send_cmd("t5", 24'h555555, 5);
    n = 0;
    while ((acc_log.size() - log_base) < 10 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("t5 reached DAT_TX", (n < 5000), 1);
    #1 sresetn = 1'b0;
    #1;
    check("t5 async stb", bus.m_wb_stb, 0);
    check("t5 async cyc", bus.m_wb_cyc, 0);
    check("t5 async tvalid", bus.m_axis_tvalid, 0);
    check("t5 async busy", busy, 0);
    check("t5 async cmd_tready", bus.cmd_tready, 1);
    repeat (3) @(negedge clk);
    sresetn = 1'b1;
    compare("t5");
    dly_min = 0; dly_max = 2;
    model_cmd(24'h0A0B0C, 2, 1'b1, 8'h77);
    send_cmd("t5b", 24'h0A0B0C, 2);
    wait_done("t5b");
    compare("t5b");

    // 6: second command presented while busy
    dly_min = 0; dly_max = 0;
    model_cmd(24'h111111, 1, 1'b1, 8'h20);
    model_cmd(24'h222222, 2, 1'b1, 8'h30);
    send_cmd("t6a", 24'h111111, 1);
    bus.cmd_addr = 24'h222222;
    bus.cmd_len = LEN_BITS'(2);
    bus.cmd_tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.cmd_tready !== 1'b1 && n < 5000);
    check("t6 ready seen", (n < 5000), 1);
    check("t6 not busy at accept", busy, 0);
    check("t6 accept cycle", cyc_cnt, sshi_ack_cyc + 1);
    @(posedge clk);
    #1 bus.cmd_tvalid = 1'b0;
    wait_done("t6");
    compare("t6");

    check("final hold violations", hold_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
